// File: rtl/rob_pkg.sv
// ---------------------------------------------------------------------------
// rob_pkg
// Shared widths and types for the rename/allocate stage. The register status
// table imports the same package.
//   REG            : MSB index of a register specifier (32 registers)
//   ROB            : MSB index of a ROB tag (8 entries)
//   ROB_DEPTH      : number of ROB entries
//   robTag_t       : ROB entry tag
//   regIdx_t       : architectural register index
//   robCnt_t       : occupancy count, 0..ROB_DEPTH inclusive
//   renameBundle_t : write bundle consumed by the register status table
// ---------------------------------------------------------------------------
package rob_pkg;

  localparam int REG       = 4;
  localparam int ROB       = 2;
  localparam int ROB_DEPTH = 2 ** (ROB + 1);

  typedef logic [ROB:0]   robTag_t;
  typedef logic [REG:0]   regIdx_t;
  typedef logic [ROB+1:0] robCnt_t;

  typedef struct packed {
    logic    we;
    regIdx_t destRegR;
    robTag_t destROB;
  } renameBundle_t;

endpackage

// File: rtl/rob_allocate_if.sv
// ---------------------------------------------------------------------------
// rob_allocate_if
// Groups the decode, commit and rename-output signals of rob_allocate.
//   slave  : the allocator (receives decode/commit, drives rename outputs)
//   master : the environment (drives decode/commit, receives rename outputs)
// When ROB_STALL_COUNT_EN is defined, the 16-bit stallCycles output is added.
// ---------------------------------------------------------------------------
interface rob_allocate_if;
  import rob_pkg::*;

  logic    instrValid;
  logic    regWrite;
  regIdx_t destReg;
  logic    rsStall;
  logic    validCommit;
  robTag_t commitROB;
  logic    flush;

  logic    stallDecode;
  logic    we;
  regIdx_t destRegR;
  robTag_t destROB;
  logic    robValid;
  logic    robFull;
  logic    robEmpty;
  logic    commitErr;
`ifdef ROB_STALL_COUNT_EN
  logic [15:0] stallCycles;
`endif

  modport slave (
    input  instrValid, regWrite, destReg, rsStall, validCommit, commitROB, flush,
    output stallDecode, we, destRegR, destROB, robValid, robFull, robEmpty, commitErr
`ifdef ROB_STALL_COUNT_EN
    , output stallCycles
`endif
  );

  modport master (
    output instrValid, regWrite, destReg, rsStall, validCommit, commitROB, flush,
    input  stallDecode, we, destRegR, destROB, robValid, robFull, robEmpty, commitErr
`ifdef ROB_STALL_COUNT_EN
    , input stallCycles
`endif
  );

endinterface

// File: rtl/rob_allocate_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// rob_ptr_ctrl
// Circular head/tail allocator with an occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_alloc    : allocate the entry at tail
//   i_commit   : retire the entry at head (caller guarantees it is legal)
//   i_flush    : collapse tail onto head+1 and empty the buffer
//   o_head     : oldest live tag
//   o_tail     : next tag to allocate
//   o_full     : all entries allocated (from registered count)
//   o_empty    : no entries allocated (from registered count)
// ---------------------------------------------------------------------------
module rob_ptr_ctrl
  import rob_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_alloc,
  input  logic    i_commit,
  input  logic    i_flush,
  output robTag_t o_head,
  output robTag_t o_tail,
  output logic    o_full,
  output logic    o_empty
);

  robTag_t r_head;
  robTag_t r_tail;
  robCnt_t r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      // The flushing instruction itself retires, so the new head is one past it.
      r_head  <= r_head + 1'b1;
      r_tail  <= r_head + 1'b1;
      r_count <= '0;
    end else begin
      if (i_alloc)  r_tail <= r_tail + 1'b1;
      if (i_commit) r_head <= r_head + 1'b1;
      case ({i_alloc, i_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_full  = (r_count == robCnt_t'(ROB_DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/rob_allocate.sv
// ---------------------------------------------------------------------------
// rob_allocate
// Rename/allocate stage: assigns each accepted decoded instruction the next
// free ROB tag and registers the rename bundle for the register status table.
//   clk          : system clock
//   globalResetN : asynchronous active-low reset
//   bus          : rob_allocate_if.slave (decode, commit, rename outputs)
// Optional macro ROB_STALL_COUNT_EN adds a saturating count of cycles in which
// a valid instruction met a full ROB.
// ---------------------------------------------------------------------------
module rob_allocate
  import rob_pkg::*;
(
  input  logic           clk,
  input  logic           globalResetN,
  rob_allocate_if.slave  bus
);

  robTag_t       w_head;
  robTag_t       w_tail;
  logic          w_full;
  logic          w_empty;
  logic          w_flush;
  logic          w_stall;
  logic          w_accept;
  logic          w_tag_match;
  logic          w_commit;
  logic          w_err;

  renameBundle_t r_bundle;
  logic          r_rob_valid;
  logic          r_commit_err;

  assign w_flush     = bus.validCommit & bus.flush;
  assign w_stall     = w_full | bus.rsStall;
  // Flush wins over allocation: the decode instruction of a flush cycle is dropped.
  assign w_accept    = bus.instrValid & ~w_stall & ~w_flush;
  assign w_tag_match = (bus.commitROB == w_head);
  // Only an in-order commit into a non-empty buffer moves the head.
  assign w_commit    = bus.validCommit & ~bus.flush & w_tag_match & ~w_empty;
  // Out-of-order tag is illegal even on a flush; committing from empty is illegal.
  assign w_err       = bus.validCommit & (~w_tag_match | (~bus.flush & w_empty));

  rob_ptr_ctrl u_ptr_ctrl (
    .clk      (clk),
    .rst_n    (globalResetN),
    .i_alloc  (w_accept),
    .i_commit (w_commit),
    .i_flush  (w_flush),
    .o_head   (w_head),
    .o_tail   (w_tail),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      r_bundle     <= '0;
      r_rob_valid  <= 1'b0;
      r_commit_err <= 1'b0;
    end else begin
      r_rob_valid <= w_accept;
      r_bundle.we <= w_accept & bus.regWrite;
      // Tag and register hold when nothing is allocated.
      if (w_accept) begin
        r_bundle.destRegR <= bus.destReg;
        r_bundle.destROB  <= w_tail;
      end
      if (w_err) r_commit_err <= 1'b1;
    end
  end

`ifdef ROB_STALL_COUNT_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      r_stall_cycles <= '0;
    end else if (w_flush) begin
      r_stall_cycles <= '0;
    end else if (bus.instrValid & w_full & (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign bus.stallCycles = r_stall_cycles;
`endif

  assign bus.stallDecode = w_stall;
  assign bus.we          = r_bundle.we;
  assign bus.destRegR    = r_bundle.destRegR;
  assign bus.destROB     = r_bundle.destROB;
  assign bus.robValid    = r_rob_valid;
  assign bus.robFull     = w_full;
  assign bus.robEmpty    = w_empty;
  assign bus.commitErr   = r_commit_err;

endmodule

// File: tb/tb_rob_allocate.sv
// ---------------------------------------------------------------------------
// tb_rob_allocate
// Scoreboard bench for rob_allocate. The driver applies one stimulus vector
// per cycle, advances a queue/array-level model of the ROB and pushes the
// expected rename bundle of every accepted instruction; a monitor pops and
// compares whenever the DUT raises robValid.
// ---------------------------------------------------------------------------
module tb_rob_allocate;
  import rob_pkg::*;

  typedef struct {
    bit      we;
    regIdx_t dreg;
    robTag_t tag;
  } exp_t;

  logic clk;
  logic globalResetN;

  rob_allocate_if bus_if ();

  rob_allocate dut (
    .clk          (clk),
    .globalResetN (globalResetN),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Model: the live entries are simply the list of tags between head and tail.
  int m_head;
  int m_tail;
  int m_count;
  bit m_err;
  int m_stall;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_head  = 0;
    m_tail  = 0;
    m_count = 0;
    m_err   = 0;
    m_stall = 0;
  endtask

  task automatic idle_inputs();
    bus_if.instrValid  = 1'b0;
    bus_if.regWrite    = 1'b0;
    bus_if.destReg     = '0;
    bus_if.rsStall     = 1'b0;
    bus_if.validCommit = 1'b0;
    bus_if.commitROB   = '0;
    bus_if.flush       = 1'b0;
  endtask

  task automatic check_status(input bit rs);
    chk("robFull",     int'(bus_if.robFull),     int'(m_count == ROB_DEPTH));
    chk("robEmpty",    int'(bus_if.robEmpty),    int'(m_count == 0));
    chk("stallDecode", int'(bus_if.stallDecode), int'((m_count == ROB_DEPTH) || rs));
    chk("commitErr",   int'(bus_if.commitErr),   int'(m_err));
`ifdef ROB_STALL_COUNT_EN
    chk("stallCycles", int'(bus_if.stallCycles), m_stall);
`endif
  endtask

  // One cycle of stimulus; the model advances according to the block rules.
  task automatic step(input bit iv, input bit rw, input int dr, input bit rs,
                      input bit vc, input int cr, input bit fl);
    bit acc;
    bit cmt;
    bit flsh;
    @(negedge clk);
    bus_if.instrValid  = iv;
    bus_if.regWrite    = rw;
    bus_if.destReg     = regIdx_t'(dr);
    bus_if.rsStall     = rs;
    bus_if.validCommit = vc;
    bus_if.commitROB   = robTag_t'(cr);
    bus_if.flush       = fl;
    #1;
    check_status(rs);

    flsh = vc && fl;
    acc  = iv && !(m_count == ROB_DEPTH) && !rs && !flsh;
    cmt  = vc && !fl && (cr == m_head) && (m_count > 0);
    if (acc) exp_q.push_back('{we: rw, dreg: regIdx_t'(dr), tag: robTag_t'(m_tail)});
    if (vc && (cr != m_head)) m_err = 1;
    if (vc && !fl && m_count == 0) m_err = 1;
    if (flsh) m_stall = 0;
    else if (iv && m_count == ROB_DEPTH && m_stall < 65535) m_stall++;
    if (flsh) begin
      m_head  = (m_head + 1) % ROB_DEPTH;
      m_tail  = m_head;
      m_count = 0;
    end else begin
      if (acc) begin
        m_tail = (m_tail + 1) % ROB_DEPTH;
        m_count++;
      end
      if (cmt) begin
        m_head = (m_head + 1) % ROB_DEPTH;
        m_count--;
      end
    end
  endtask

  task automatic alloc(input int dr, input bit rw);
    step(1'b1, rw, dr, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic commit(input int cr, input bit iv);
    step(iv, 1'b1, 9, 1'b0, 1'b1, cr, 1'b0);
  endtask

  // Reset is asserted between clock edges and checked before the next edge.
  task automatic mid_reset();
    @(negedge clk);
    idle_inputs();
    #2;
    globalResetN = 1'b0;
    #1;
    chk("rst robEmpty",  int'(bus_if.robEmpty),  1);
    chk("rst robFull",   int'(bus_if.robFull),   0);
    chk("rst robValid",  int'(bus_if.robValid),  0);
    chk("rst we",        int'(bus_if.we),        0);
    chk("rst destROB",   int'(bus_if.destROB),   0);
    chk("rst destRegR",  int'(bus_if.destRegR),  0);
    chk("rst commitErr", int'(bus_if.commitErr), 0);
`ifdef ROB_STALL_COUNT_EN
    chk("rst stallCycles", int'(bus_if.stallCycles), 0);
`endif
    model_reset();
    exp_q.delete();
    @(negedge clk);
    globalResetN = 1'b1;
  endtask

  // Monitor: compare each presented allocation with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (globalResetN && bus_if.robValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_alloc actual=robValid=1 required=no allocation tag=%0d @%0t",
                   bus_if.destROB, $time);
        end else begin
          e = exp_q.pop_front();
          chk("alloc destROB",  int'(bus_if.destROB),  int'(e.tag));
          chk("alloc destRegR", int'(bus_if.destRegR), int'(e.dreg));
          chk("alloc we",       int'(bus_if.we),       int'(e.we));
          $display("alloc tag=%0d reg=%0d we=%0d @%0t",
                   bus_if.destROB, bus_if.destRegR, bus_if.we, $time);
        end
      end else if (globalResetN) begin
        chk("idle we", int'(bus_if.we), 0);
      end
    end
  end

  initial begin
    idle_inputs();
    model_reset();
    globalResetN = 1'b0;
    #12;
    check_status(1'b0);
    chk("reset robValid", int'(bus_if.robValid), 0);
    chk("reset we",       int'(bus_if.we),       0);
    @(negedge clk);
    globalResetN = 1'b1;

    // Fill all eight entries, then a ninth request must stall.
    for (int i = 1; i <= 8; i++) alloc(i, 1'b1);
    alloc(9, 1'b1);
    // Full with same-cycle commit: blocked now, wrapped tag 0 next cycle.
    commit(0, 1'b1);
    alloc(10, 1'b1);
    alloc(11, 1'b1);

    // Flush with three live entries: tags restart at head+1.
    mid_reset();
    for (int i = 1; i <= 3; i++) alloc(i, 1'b1);
    step(1'b1, 1'b1, 20, 1'b0, 1'b1, 0, 1'b1);
    alloc(21, 1'b1);
    // Allocation without a destination write.
    alloc(22, 1'b0);

    // Out-of-order commit tag while head is 2.
    mid_reset();
    for (int i = 1; i <= 5; i++) alloc(i, 1'b1);
    commit(0, 1'b0);
    commit(1, 1'b0);
    commit(5, 1'b0);
    commit(2, 1'b0);
    commit(3, 1'b0);
    // Commit into an empty ROB is illegal and must not underflow.
    mid_reset();
    commit(0, 1'b0);
    alloc(7, 1'b1);

    // Reset mid-operation with four live entries.
    mid_reset();
    for (int i = 1; i <= 4; i++) alloc(i, 1'b1);
    mid_reset();

    // Randomized traffic with periodic resets.
    for (int n = 0; n < 600; n++) begin
      bit iv, rw, rs, vc, fl;
      int dr, cr;
      if (n % 150 == 149) mid_reset();
      iv = ($urandom_range(99) < 75);
      rw = $urandom_range(1);
      dr = $urandom_range(31);
      rs = ($urandom_range(99) < 15);
      vc = (m_count > 0) ? ($urandom_range(99) < 35) : ($urandom_range(99) < 3);
      cr = ($urandom_range(99) < 8) ? $urandom_range(ROB_DEPTH - 1) : m_head;
      fl = vc && (m_count > 0) && ($urandom_range(99) < 10);
      step(iv, rw, dr, rs, vc, cr, fl);
    end

    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
